// File: rtl/rtc_pkg.sv
// Shared types, BCD limits and helpers for the BCD real-time clock.
package rtc_pkg;

    // FSM state; the encoding is exported on mode_o.
    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_SET_HH  = 3'd1,
        ST_SET_MM  = 3'd2,
        ST_SET_AHH = 3'd3,
        ST_SET_AMM = 3'd4
    } rtc_state_e;

    localparam logic [7:0] BCD_MAX_HH = 8'h23;
    localparam logic [7:0] BCD_MAX_MS = 8'h59;

    // Two-digit BCD increment that wraps max_v -> 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        if (v == max_v) begin
            return 8'h00;
        end
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // 24h BCD hours to 12h display hours: 00 -> 12, 13..23 -> 01..11.
    function automatic logic [7:0] to_12h(input logic [7:0] hours_bcd);
        logic [4:0] bin;
        bin = 5'(hours_bcd[7:4]) * 5'd10 + 5'(hours_bcd[3:0]);
        if (bin == 5'd0) begin
            bin = 5'd12;
        end else if (bin > 5'd12) begin
            bin = bin - 5'd12;
        end
        if (bin >= 5'd10) begin
            return {4'd1, 4'(bin - 5'd10)};
        end
        return {4'd0, bin[3:0]};
    endfunction

endpackage

// File: rtl/rtc_bcd_clock_if.sv
// Board-side bundle of the clock core: buttons, switches, digits, buzzer.
interface rtc_bcd_clock_if #(
    parameter int NUM_DIGITS = 6,
    parameter int BUZZ_W     = 10
);
    logic [1:0]              button_i;
    logic [7:0]              switch_i;
    logic [4*NUM_DIGITS-1:0] digits_o;
    logic                    pm_o;
    logic [2:0]              mode_o;
    logic                    tick_o;
    logic [BUZZ_W-1:0]       buzzer_o;

    // Board / stimulus side.
    modport master (
        output button_i, switch_i,
        input  digits_o, pm_o, mode_o, tick_o, buzzer_o
    );

    // Clock core side.
    modport slave (
        input  button_i, switch_i,
        output digits_o, pm_o, mode_o, tick_o, buzzer_o
    );
endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps MAX_BCD -> 00; carry_o flags the wrap.
module bcd_mod_counter
    import rtc_pkg::*;
#(
    parameter logic [7:0] MAX_BCD = 8'h59
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       inc,
    input  logic       clr,
    output logic       carry_o,
    output logic [7:0] value_o
);
    logic [7:0] value_q;

    // Clear has priority over increment.
    always_ff @(posedge clk_clk) begin
        if (reset_reset || clr) begin
            value_q <= 8'h00;
        end else if (inc) begin
            value_q <= bcd_inc(value_q, MAX_BCD);
        end
    end

    assign carry_o = inc && (value_q == MAX_BCD);
    assign value_o = value_q;

endmodule

// File: rtl/rtc_bcd_clock.sv
// BCD real-time clock: prescaler, set-mode FSM, alarm/buzzer and digit mux.
module rtc_bcd_clock
    import rtc_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int NUM_DIGITS  = 6,
    parameter int ALARM_SECS  = 60,
    parameter int BUZZ_W      = 10
) (
    input  logic            clk_clk,
    input  logic            reset_reset,
    rtc_bcd_clock_if.slave  bus
);
    localparam int CNT_W  = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam int RING_W = $clog2(ALARM_SECS + 1);
    localparam int NPAIR  = NUM_DIGITS / 2;
    localparam int PAIR_OFS = 3 - NPAIR;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_FREQ_HZ - 1);
    localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(CLK_FREQ_HZ / 2);
    localparam logic [RING_W-1:0] RING_LAST = RING_W'(ALARM_SECS - 1);

    if (NUM_DIGITS != 4 && NUM_DIGITS != 6) begin : g_bad_digits
        $error("rtc_bcd_clock: NUM_DIGITS must be 4 or 6");
    end

    rtc_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        btn_q;
    logic              sw_alm_q;
    logic              ring_q;
    logic [RING_W-1:0] ring_cnt_q;
    logic [4*NUM_DIGITS-1:0] digits_q;
    logic [4*NUM_DIGITS-1:0] digits_d;
    logic              pm_q;

    logic [1:0] btn_rise;
    logic       consume, mode_adv, inc_act;
    logic       running, tick, phase;
    logic [7:0] sec_v, min_v, hr_v, alm_mm_v, alm_hh_v;
    logic       sec_carry, min_carry;
    logic       unused_hr_carry, unused_alm_mm_carry, unused_alm_hh_carry;
    logic [7:0] min_after, hr_after;
    logic       ring_start, sw_fall;
    logic       show_alarm;
    logic [7:0] pair_val [3];

    // Button/switch edge detection; a press that silences the alarm is swallowed.
    assign btn_rise = bus.button_i & ~btn_q;
    assign sw_fall  = sw_alm_q & ~bus.switch_i[1];
    assign consume  = ring_q && (|btn_rise);
    assign mode_adv = btn_rise[0] && !consume;
    assign inc_act  = btn_rise[1] && !btn_rise[0] && !consume;

    // Time is frozen only while the time itself is being edited.
    assign running = (state_q != ST_SET_HH) && (state_q != ST_SET_MM);
    assign tick    = running && (cnt_q == CNT_LAST);
    assign phase   = cnt_q < CNT_HALF;

    // Edge-detect history registers.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            btn_q    <= 2'b00;
            sw_alm_q <= 1'b0;
        end else begin
            btn_q    <= bus.button_i;
            sw_alm_q <= bus.switch_i[1];
        end
    end

    // 1 Hz prescaler, parked at 0 while time is being set.
    always_ff @(posedge clk_clk) begin
        if (reset_reset || !running || cnt_q == CNT_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    bcd_mod_counter #(.MAX_BCD(BCD_MAX_MS)) u_sec (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .inc(tick), .clr(state_q == ST_SET_MM && mode_adv),
        .carry_o(sec_carry), .value_o(sec_v)
    );

    bcd_mod_counter #(.MAX_BCD(BCD_MAX_MS)) u_min (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .inc(sec_carry || (state_q == ST_SET_MM && inc_act)), .clr(1'b0),
        .carry_o(min_carry), .value_o(min_v)
    );

    // Only a running carry reaches hours; editing minutes never does.
    bcd_mod_counter #(.MAX_BCD(BCD_MAX_HH)) u_hr (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .inc((min_carry && tick) || (state_q == ST_SET_HH && inc_act)), .clr(1'b0),
        .carry_o(unused_hr_carry), .value_o(hr_v)
    );

    bcd_mod_counter #(.MAX_BCD(BCD_MAX_MS)) u_alm_mm (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .inc(state_q == ST_SET_AMM && inc_act), .clr(1'b0),
        .carry_o(unused_alm_mm_carry), .value_o(alm_mm_v)
    );

    bcd_mod_counter #(.MAX_BCD(BCD_MAX_HH)) u_alm_hh (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .inc(state_q == ST_SET_AHH && inc_act), .clr(1'b0),
        .carry_o(unused_alm_hh_carry), .value_o(alm_hh_v)
    );

    // Set-mode FSM, advanced by an unconsumed MODE edge.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q <= ST_RUN;
        end else if (mode_adv) begin
            case (state_q)
                ST_RUN:     state_q <= ST_SET_HH;
                ST_SET_HH:  state_q <= ST_SET_MM;
                ST_SET_MM:  state_q <= ST_SET_AHH;
                ST_SET_AHH: state_q <= ST_SET_AMM;
                default:    state_q <= ST_RUN;
            endcase
        end
    end

    // The alarm compares against the hh:mm that this tick is about to produce.
    assign min_after  = bcd_inc(min_v, BCD_MAX_MS);
    assign hr_after   = (min_v == BCD_MAX_MS) ? bcd_inc(hr_v, BCD_MAX_HH) : hr_v;
    assign ring_start = tick && bus.switch_i[1] && (state_q == ST_RUN) &&
                        (sec_v == BCD_MAX_MS) && (min_after == alm_mm_v) &&
                        (hr_after == alm_hh_v);

    // Ring control: start on the alarm minute, stop on timeout/button/switch/mode.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            ring_q     <= 1'b0;
            ring_cnt_q <= '0;
        end else if (consume || sw_fall || state_q != ST_RUN) begin
            ring_q     <= 1'b0;
            ring_cnt_q <= '0;
        end else if (ring_start) begin
            ring_q     <= 1'b1;
            ring_cnt_q <= '0;
        end else if (ring_q && tick) begin
            if (ring_cnt_q == RING_LAST) begin
                ring_q <= 1'b0;
            end else begin
                ring_cnt_q <= ring_cnt_q + 1'b1;
            end
        end
    end

    // Display source: alarm setting while editing it, otherwise live time.
    always_comb begin
        show_alarm  = (state_q == ST_SET_AHH) || (state_q == ST_SET_AMM);
        pair_val[2] = show_alarm ? alm_hh_v : hr_v;
        if (bus.switch_i[0]) begin
            pair_val[2] = to_12h(pair_val[2]);
        end
        pair_val[1] = show_alarm ? alm_mm_v : min_v;
        pair_val[0] = show_alarm ? 8'h00 : sec_v;
    end

    // Pack the displayed digit pairs, least significant pair at the bottom.
    for (genvar gi = 0; gi < NPAIR; gi++) begin : g_pair
        assign digits_d[8*gi +: 8] = pair_val[gi + PAIR_OFS];
    end

    // Registered display outputs.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            digits_q <= '0;
            pm_q     <= 1'b0;
        end else begin
            digits_q <= digits_d;
            pm_q     <= (hr_v >= 8'h12);
        end
    end

    assign bus.digits_o = digits_q;
    assign bus.pm_o     = pm_q;
    assign bus.mode_o   = state_q;
    assign bus.tick_o   = tick;
    assign bus.buzzer_o = {BUZZ_W{ring_q & phase}};

endmodule

// File: tb/tb_rtc_bcd_clock.sv
// Self-checking bench for rtc_bcd_clock (CLK_FREQ_HZ=4, NUM_DIGITS=6).
module tb_rtc_bcd_clock;
    localparam int F  = 4;
    localparam int ND = 6;
    localparam int BW = 10;
    localparam logic [BW-1:0] BUZZ_ON = '1;

    logic clk_clk = 1'b0;
    logic reset_reset = 1'b1;
    always #5 clk_clk = ~clk_clk;

    rtc_bcd_clock_if #(.NUM_DIGITS(ND), .BUZZ_W(BW)) bus ();

    rtc_bcd_clock #(.CLK_FREQ_HZ(F), .NUM_DIGITS(ND), .ALARM_SECS(60), .BUZZ_W(BW)) dut (
        .clk_clk(clk_clk),
        .reset_reset(reset_reset),
        .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        int          due;
        logic [23:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        int          h;
        int          m;
        bit          sw0;
        logic [15:0] exp_hm;
        bit          exp_pm;
    } vec_t;
    vec_t tbl[7];

    int model_secs = 0;
    bit cmp_en = 0;
    bit per_en = 0;
    bit prev_run = 0;
    int last_tick = -1;

    function automatic logic [7:0] to_bcd(int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic logic [23:0] exp_digits(int s, bit h12);
        int hh;
        hh = s / 3600;
        if (h12) hh = (hh == 0) ? 12 : ((hh > 12) ? hh - 12 : hh);
        return {to_bcd(hh), to_bcd((s / 60) % 60), to_bcd(s % 60)};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: %h (cycle %0d)", name, act, cyc);
        end
    endtask

    // Scoreboard: each tick pushes the time it should produce; popped two cycles later.
    always @(negedge clk_clk) begin
        sb_t e;
        cyc++;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            e = sb_q.pop_front();
            if (cmp_en && bus.mode_o == 3'd0 && prev_run)
                check("sb_digits", 32'(bus.digits_o), 32'(e.exp));
        end
        if (bus.tick_o) begin
            if (per_en && last_tick >= 0) check("tick_period", cyc - last_tick, 4);
            last_tick = cyc;
            model_secs = (model_secs + 1) % 86400;
            if (cmp_en) sb_q.push_back('{cyc + 2, exp_digits(model_secs, bus.switch_i[0])});
        end
        prev_run = (bus.mode_o == 3'd0);
    end

    task automatic step(int n);
        repeat (n) @(negedge clk_clk);
    endtask

    task automatic press(logic [1:0] mask);
        bus.button_i = mask;
        step(1);
        bus.button_i = 2'b00;
        step(1);
    endtask

    task automatic do_reset();
        cmp_en = 0;
        step(1);
        reset_reset = 1'b1;
        step(3);
        sb_q.delete();
        model_secs = 0;
        last_tick = -1;
        reset_reset = 1'b0;
        cmp_en = 1;
    endtask

    task automatic set_all(int h, int m, int ah, int am);
        press(2'b01);
        repeat (h) press(2'b10);
        press(2'b01);
        repeat (m) press(2'b10);
        model_secs = h * 3600 + m * 60;
        press(2'b01);
        repeat (ah) press(2'b10);
        press(2'b01);
        repeat (am) press(2'b10);
        press(2'b01);
    endtask

    task automatic wait_digits(string name, logic [23:0] exp, int bound);
        int n = 0;
        while (bus.digits_o !== exp && n < bound) begin
            step(1);
            n++;
        end
        check(name, 32'(bus.digits_o), 32'(exp));
    endtask

    task automatic wait_ring(string name);
        int n = 0;
        while (bus.buzzer_o === '0 && n < 400) begin
            step(1);
            n++;
        end
        check(name, 32'(bus.buzzer_o), 32'(BUZZ_ON));
    endtask

    task automatic count_buzz(int n, output int highs);
        highs = 0;
        for (int i = 0; i < n; i++) begin
            step(1);
            if (bus.buzzer_o !== '0) highs++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int highs;
        tbl[0] = '{13,  5, 1'b1, 16'h0105, 1'b1};
        tbl[1] = '{13,  5, 1'b0, 16'h1305, 1'b1};
        tbl[2] = '{ 0,  7, 1'b1, 16'h1207, 1'b0};
        tbl[3] = '{12,  0, 1'b1, 16'h1200, 1'b1};
        tbl[4] = '{11, 59, 1'b1, 16'h1159, 1'b0};
        tbl[5] = '{23,  4, 1'b0, 16'h2304, 1'b1};
        tbl[6] = '{23,  0, 1'b1, 16'h1100, 1'b1};

        bus.button_i = 2'b00;
        bus.switch_i = 8'h00;

        // Reset state.
        step(3);
        check("rst_digits", 32'(bus.digits_o), 32'h0);
        check("rst_mode",   32'(bus.mode_o),   32'h0);
        check("rst_pm",     32'(bus.pm_o),     32'h0);
        check("rst_tick",   32'(bus.tick_o),   32'h0);
        check("rst_buzzer", 32'(bus.buzzer_o), 32'h0);

        // Free run: 60 ticks in 240 cycles, tick every 4th cycle.
        do_reset();
        per_en = 1;
        step(241);
        check("run240", 32'(bus.digits_o), 32'h000100);
        per_en = 0;

        // 23:59 rolls over to 00:00:00, then 00:00:01.
        do_reset();
        set_all(23, 59, 0, 0);
        wait_digits("rollover", 24'h000000, 300);
        check("rollover_pm", 32'(bus.pm_o), 32'h0);
        wait_digits("rollover_p1", 24'h000001, 8);

        // Display table: 12h/24h mapping and pm flag.
        for (int i = 0; i < 7; i++) begin
            do_reset();
            bus.switch_i = {7'b0, tbl[i].sw0};
            set_all(tbl[i].h, tbl[i].m, 0, 0);
            step(2);
            check($sformatf("tbl%0d_hhmm", i), 32'(bus.digits_o[23:8]), 32'(tbl[i].exp_hm));
            check($sformatf("tbl%0d_pm", i), 32'(bus.pm_o), 32'(tbl[i].exp_pm));
        end
        bus.switch_i = 8'h00;

        // Alarm 00:01: 2 on / 2 off burst, 60 ticks long.
        do_reset();
        bus.switch_i = 8'h02;
        set_all(0, 0, 0, 1);
        wait_ring("ring_start");
        highs = 1;
        for (int i = 1; i < 8; i++) begin
            step(1);
            check($sformatf("buzz_pat%0d", i), 32'(bus.buzzer_o), ((i % 4) < 2) ? 32'(BUZZ_ON) : 32'h0);
            if (i == 1) check("ring_time", 32'(bus.digits_o), 32'h000100);
            if ((i % 4) < 2 && bus.buzzer_o !== '0) highs++;
        end
        begin
            int more;
            count_buzz(292, more);
            check("ring_len", highs + more, 120);
        end

        // MODE edge while ringing stops it and does not leave RUN.
        do_reset();
        bus.switch_i = 8'h02;
        set_all(0, 0, 0, 1);
        wait_ring("ring2_start");
        bus.button_i = 2'b01;
        step(1);
        check("ring2_mode", 32'(bus.mode_o), 32'h0);
        bus.button_i = 2'b00;
        count_buzz(8, highs);
        check("ring2_silent", highs, 0);

        // Alarm-enable falling edge stops the ring.
        do_reset();
        bus.switch_i = 8'h02;
        set_all(0, 0, 0, 1);
        wait_ring("ring3_start");
        bus.switch_i = 8'h00;
        step(1);
        count_buzz(8, highs);
        check("ring3_silent", highs, 0);

        // MODE and INC together in SET_HH: MODE wins, hours unchanged.
        do_reset();
        press(2'b01);
        repeat (3) press(2'b10);
        press(2'b11);
        check("modeinc_mode", 32'(bus.mode_o), 32'h2);
        step(1);
        check("modeinc_time", 32'(bus.digits_o), 32'h030000);

        // Reset while ringing.
        do_reset();
        bus.switch_i = 8'h02;
        set_all(0, 0, 0, 1);
        wait_ring("ring4_start");
        cmp_en = 0;
        step(1);
        reset_reset = 1'b1;
        step(1);
        check("rring_digits", 32'(bus.digits_o), 32'h0);
        check("rring_buzzer", 32'(bus.buzzer_o), 32'h0);
        check("rring_mode",   32'(bus.mode_o),   32'h0);
        check("rring_pm",     32'(bus.pm_o),     32'h0);
        check("rring_tick",   32'(bus.tick_o),   32'h0);

        // Reset while in SET_MM.
        reset_reset = 1'b0;
        bus.switch_i = 8'h00;
        press(2'b01);
        press(2'b10);
        press(2'b10);
        press(2'b01);
        check("rset_in_mm", 32'(bus.mode_o), 32'h2);
        reset_reset = 1'b1;
        step(1);
        check("rset_mode",   32'(bus.mode_o),   32'h0);
        check("rset_digits", 32'(bus.digits_o), 32'h0);
        reset_reset = 1'b0;
        step(2);
        check("rset_time", 32'(bus.digits_o), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rtc_bcd_clock.md
Name: rtc_bcd_clock

Overview:
- Parametrised BCD real-time clock core that drives the seven-segment digit exports from button and switch inputs.
- Includes a set-mode state machine, a programmable alarm with buzzer pattern, and a selectable 12h/24h display.
- Sits between the board I/O (buttons, switches, buzzer, BCD digit buses) and the seven-segment decoders.
- Replaces the software-timed clock loop with hardware timekeeping.

Parameters:
- CLK_FREQ_HZ, 50000000, input clock frequency; the 1 Hz tick is derived from it (benches use 4).
- NUM_DIGITS, 6, 6 = HH:MM:SS, 4 = HH:MM; any other value is illegal (elaboration error).
- ALARM_SECS, 60, maximum ring duration in seconds.
- BUZZ_W, 10, buzzer output bus width.

Ports:
- clk_clk  in  1  system clock
- reset_reset  in  1  synchronous, active-high reset
- button_i  in  2  [0]=MODE, [1]=INC; debounced levels, rising-edge detected internally
- switch_i  in  8  [0]=12h display, [1]=alarm enable, [7:2] reserved/ignored
- digits_o  out  4*NUM_DIGITS  BCD digits, LS nibble = least significant displayed digit
- pm_o  out  1  hours >= 12 (valid in both display modes)
- mode_o  out  3  current FSM state encoding
- tick_o  out  1  one-cycle pulse per second
- buzzer_o  out  BUZZ_W  buzzer drive

Behaviour:
- Reset (synchronous, same cycle):
  - time = 00:00:00, alarm = 00:00, state = RUN, prescaler = 0, ring = 0, edge-detect registers = 0.
  - All outputs = 0; mode_o = RUN = 3'd0.
  - Reset mid-ring or mid-set aborts with no residue.
- Prescaler:
  - Counts 0..CLK_FREQ_HZ-1.
  - tick_o = 1 in the cycle the count equals CLK_FREQ_HZ-1; the count then wraps to 0.
  - phase = 1 while count < CLK_FREQ_HZ/2.
- Time registers are BCD: hours 00-23, minutes 00-59, seconds 00-59.
  - On tick: seconds increment; 59 -> 00 carries to minutes; minutes 59 -> 00 carries to hours; hours 23 -> 00.
- FSM (a MODE rising edge advances): RUN(0) -> SET_HH(1) -> SET_MM(2) -> SET_AHH(3) -> SET_AMM(4) -> RUN.
  - SET_HH, SET_MM:
    - Prescaler held at 0, no tick, time frozen.
    - INC increments hours (23 -> 00) or minutes (59 -> 00); no carry.
    - Exit from SET_MM clears seconds to 00.
  - SET_AHH, SET_AMM:
    - Time keeps running.
    - INC increments alarm hours or minutes with the same wrap, no carry.
    - Display shows the alarm time; seconds digits = 00.
  - RUN: INC ignored.
- MODE and INC rising edges in the same cycle: MODE wins, INC discarded.
- Display:
  - digits_o is registered, 1-cycle latency from internal state.
  - 6 digits: H1 H0 M1 M0 S1 S0. 4 digits: H1 H0 M1 M0.
  - switch_i[0]=1 maps hours 00 -> 12 and 13..23 -> 01..11. pm_o is unaffected by this mapping.
- Alarm:
  - Ring starts on the tick that makes seconds == 00 when hh:mm == alarm, switch_i[1]=1 and state == RUN.
  - Ring stops on any of:
    - ALARM_SECS ticks elapsed;
    - any button rising edge (that edge is consumed and does not advance the FSM or increment);
    - switch_i[1] falling (stop takes effect the next cycle);
    - leaving RUN.
  - buzzer_o = {BUZZ_W{ring & phase}}, i.e. a 1 Hz, 50% duty burst.

Decomposition:
- Package rtc_pkg holds:
  - state enum and encodings;
  - BCD limit constants (23, 59);
  - function to_12h(hours_bcd) returning display hours.
- Sub-module bcd_mod_counter:
  - Parameter MAX_BCD.
  - Ports: clk_clk, reset_reset, inc, clr, carry_o, value_o[7:0]; wraps MAX -> 00.
  - Instantiated for seconds, minutes, hours, alarm minutes and alarm hours.
  - The top level holds the prescaler, FSM, edge detect, compare, display mux and buzzer.

Test Plan (CLK_FREQ_HZ=4, NUM_DIGITS=6):
- Release reset, run 240 cycles -> 60 ticks, digits_o = 0x000100; tick_o pulses exactly every 4th cycle.
- Set time to 23:59 (MODE, 23×INC, MODE, 59×INC), then 2×MODE and 1×MODE back to RUN, run 240 cycles -> 00:00:00, then 00:00:01 on the next tick, pm_o = 0.
- switch_i[0]=1 at time 13:05:00 -> digits_o = 0x010500, pm_o = 1; at 00:xx -> hours digits show 12.
- Alarm set to 00:01, switch_i[1]=1, time passes 00:00:59 -> ring; buzzer_o = 0x3FF for 2 cycles, then 0 for 2 cycles, repeating; ends after 60 ticks.
- While ringing, a MODE rising edge -> ring = 0 next cycle and mode_o stays 0. Separately, MODE and INC rising together in SET_HH -> mode_o = 2, hours unchanged.
- Assert reset_reset mid-ring while in SET_MM -> all outputs 0 the next cycle; state RUN, time 00:00:00.
